// File: rtl/riscv_pkg.sv
// Shared types for the RISC-V pipeline control blocks.
// Holds forward selects, hazard FSM states and stall/flush bundles.
package riscv_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_WB  = 2'd1,
        FWD_MEM = 2'd2
    } fwd_sel_e;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FAULT    = 2'd2
    } hz_state_e;

    typedef struct packed {
        logic stall_f;
        logic stall_d;
        logic stall_e;
        logic stall_m;
        logic flush_d;
        logic flush_e;
        logic flush_w;
    } hz_ctrl_t;

    localparam hz_ctrl_t HZ_NONE  = 7'b0000000;
    localparam hz_ctrl_t HZ_MEM   = 7'b1111001;
    localparam hz_ctrl_t HZ_REDIR = 7'b0000110;
    localparam hz_ctrl_t HZ_LDUSE = 7'b1100010;

endpackage

// File: rtl/hazard_ctrl_forward_unit.sv
// Combinational operand forward select for one E-stage source.
// Ports: rs_e_i, rd_m_i/reg_write_m_i, rd_w_i/reg_write_w_i in; fwd_o out.
module forward_unit
    import riscv_pkg::*;
(
    input  logic [4:0] rs_e_i,
    input  logic [4:0] rd_m_i,
    input  logic       reg_write_m_i,
    input  logic [4:0] rd_w_i,
    input  logic       reg_write_w_i,
    output fwd_sel_e   fwd_o
);

    always_comb begin
        fwd_o = FWD_RF;
        if (reg_write_m_i && (rd_m_i != 5'd0) && (rd_m_i == rs_e_i)) begin
            fwd_o = FWD_MEM;
        end else if (reg_write_w_i && (rd_w_i != 5'd0) && (rd_w_i == rs_e_i)) begin
            fwd_o = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard control: forwarding, load-use, redirect, memory wait/timeout.
// Ports: register ids and hazard sources in; stalls/flushes, forwards,
// fault and saturating stall/flush performance counters out.
module hazard_ctrl
    import riscv_pkg::*;
#(
    parameter int XLEN        = riscv_pkg::XLEN,
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic             ResultSrcE0,
    input  logic             PCSrcE,
    input  logic [4:0]       RdM,
    input  logic             RegWriteM,
    input  logic [4:0]       RdW,
    input  logic             RegWriteW,
    input  logic             dmem_req_M,
    input  logic             dmem_ready,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output fwd_sel_e         ForwardAE,
    output fwd_sel_e         ForwardBE,
    output logic             fault,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int WC_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);

    if ((CNT_W < 1) || (CNT_W > XLEN)) begin : g_cnt_w_bad
        $error("hazard_ctrl: CNT_W must be within 1..XLEN");
    end

    hz_state_e        state_q, state_d;
    logic [WC_W-1:0]  wait_q, wait_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    hz_ctrl_t         ctrl;
    logic             mem_stall;
    logic             load_use;

    forward_unit u_fwd_a (
        .rs_e_i        (Rs1E),
        .rd_m_i        (RdM),
        .reg_write_m_i (RegWriteM),
        .rd_w_i        (RdW),
        .reg_write_w_i (RegWriteW),
        .fwd_o         (ForwardAE)
    );

    forward_unit u_fwd_b (
        .rs_e_i        (Rs2E),
        .rd_m_i        (RdM),
        .reg_write_m_i (RegWriteM),
        .rd_w_i        (RdW),
        .reg_write_w_i (RegWriteW),
        .fwd_o         (ForwardBE)
    );

    assign mem_stall = dmem_req_M & ~dmem_ready;
    assign load_use  = ResultSrcE0 & (RdE != 5'd0) &
                       ((RdE == Rs1D) | (RdE == Rs2D));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            wait_q      <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        unique case (state_q)
            RUN: begin
                if (mem_stall) begin
                    state_d = MEM_WAIT;
                    wait_d  = WC_W'(1);
                end
            end
            MEM_WAIT: begin
                if (!mem_stall) begin
                    state_d = RUN;
                    wait_d  = '0;
                end else if (wait_q == WC_W'(MEM_TIMEOUT)) begin
                    state_d = FAULT;
                end else begin
                    wait_d = wait_q + WC_W'(1);
                end
            end
            FAULT: begin
                state_d = FAULT;
            end
            default: begin
                state_d = RUN;
                wait_d  = '0;
            end
        endcase
    end

    // Memory stall outranks redirect, which outranks load-use; the
    // outputs are forced quiet while reset is held.
    always_comb begin
        ctrl = HZ_NONE;
        if (!rst_n) begin
            ctrl = HZ_NONE;
        end else if ((state_q == FAULT) || mem_stall) begin
            ctrl = HZ_MEM;
        end else if (PCSrcE) begin
            ctrl = HZ_REDIR;
        end else if (load_use) begin
            ctrl = HZ_LDUSE;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (ctrl.stall_f && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (ctrl.flush_e && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    assign StallF    = ctrl.stall_f;
    assign StallD    = ctrl.stall_d;
    assign StallE    = ctrl.stall_e;
    assign StallM    = ctrl.stall_m;
    assign FlushD    = ctrl.flush_d;
    assign FlushE    = ctrl.flush_e;
    assign FlushW    = ctrl.flush_w;
    assign fault     = (state_q == FAULT);
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl (MEM_TIMEOUT=4, CNT_W=4).
// Driver queues hand-computed outputs; a negedge monitor pops and compares.
module tb_hazard_ctrl;
    import riscv_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n = 1'b1;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic       ResultSrcE0, PCSrcE, RegWriteM, RegWriteW;
    logic       dmem_req_M, dmem_ready;
    logic       StallF, StallD, StallE, StallM;
    logic       FlushD, FlushE, FlushW, fault;
    fwd_sel_e   ForwardAE, ForwardBE;
    logic [3:0] stall_cnt, flush_cnt;

    hazard_ctrl #(
        .MEM_TIMEOUT (4),
        .CNT_W       (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .Rs1D        (Rs1D),
        .Rs2D        (Rs2D),
        .Rs1E        (Rs1E),
        .Rs2E        (Rs2E),
        .RdE         (RdE),
        .ResultSrcE0 (ResultSrcE0),
        .PCSrcE      (PCSrcE),
        .RdM         (RdM),
        .RegWriteM   (RegWriteM),
        .RdW         (RdW),
        .RegWriteW   (RegWriteW),
        .dmem_req_M  (dmem_req_M),
        .dmem_ready  (dmem_ready),
        .StallF      (StallF),
        .StallD      (StallD),
        .StallE      (StallE),
        .StallM      (StallM),
        .FlushD      (FlushD),
        .FlushE      (FlushE),
        .FlushW      (FlushW),
        .ForwardAE   (ForwardAE),
        .ForwardBE   (ForwardBE),
        .fault       (fault),
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt)
    );

    typedef struct packed {
        logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
        logic       ld, pc, rwm, rww, req, rdy;
    } in_t;

    // sf = {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW}
    typedef struct packed {
        logic [6:0] sf;
        fwd_sel_e   fa;
        fwd_sel_e   fb;
        logic       flt;
        logic [3:0] sc;
        logic [3:0] fc;
    } obs_t;

    localparam logic [6:0] NONE = 7'b0000000;
    localparam logic [6:0] LU   = 7'b1100010;
    localparam logic [6:0] RD   = 7'b0000110;
    localparam logic [6:0] MS   = 7'b1111001;

    obs_t  exp_q[$];
    string nm_q[$];
    int    total = 0;
    int    bad   = 0;
    logic [3:0] m_s = 4'd0;
    logic [3:0] m_f = 4'd0;
    in_t   nx;

    task automatic apply_in();
        Rs1D        = nx.rs1d;
        Rs2D        = nx.rs2d;
        Rs1E        = nx.rs1e;
        Rs2E        = nx.rs2e;
        RdE         = nx.rde;
        RdM         = nx.rdm;
        RdW         = nx.rdw;
        ResultSrcE0 = nx.ld;
        PCSrcE      = nx.pc;
        RegWriteM   = nx.rwm;
        RegWriteW   = nx.rww;
        dmem_req_M  = nx.req;
        dmem_ready  = nx.rdy;
    endtask

    task automatic cyc(input string nm, input logic [6:0] sf,
                       input fwd_sel_e fa, input fwd_sel_e fb,
                       input logic flt);
        obs_t e;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        apply_in();
        e = '{sf: sf, fa: fa, fb: fb, flt: flt, sc: m_s, fc: m_f};
        exp_q.push_back(e);
        nm_q.push_back(nm);
        if (sf[6] && (m_s != 4'hf)) m_s = m_s + 4'd1;
        if (sf[1] && (m_f != 4'hf)) m_f = m_f + 4'd1;
    endtask

    task automatic rst_cyc(input string nm, input fwd_sel_e fa,
                           input fwd_sel_e fb);
        obs_t e;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        apply_in();
        m_s = 4'd0;
        m_f = 4'd0;
        e = '{sf: NONE, fa: fa, fb: fb, flt: 1'b0, sc: 4'd0, fc: 4'd0};
        exp_q.push_back(e);
        nm_q.push_back(nm);
    endtask

    initial begin : monitor
        obs_t  e, a;
        string n;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n = nm_q.pop_front();
                a.sf  = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};
                a.fa  = ForwardAE;
                a.fb  = ForwardBE;
                a.flt = fault;
                a.sc  = stall_cnt;
                a.fc  = flush_cnt;
                total = total + 1;
                if (a !== e) begin
                    bad = bad + 1;
                    $display("FAIL %s: got sf=%b fa=%0d fb=%0d flt=%b sc=%0d fc=%0d want sf=%b fa=%0d fb=%0d flt=%b sc=%0d fc=%0d",
                             n, a.sf, a.fa, a.fb, a.flt, a.sc, a.fc,
                             e.sf, e.fa, e.fb, e.flt, e.sc, e.fc);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: run did not end, got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        nx = '0;
        apply_in();

        // reset with a pending memory stall: outputs quiet, forwards live
        nx = '0; nx.req = 1; nx.rs1e = 5; nx.rdm = 5; nx.rwm = 1;
        rst_cyc("reset", FWD_MEM, FWD_RF);
        nx = '0;
        cyc("idle", NONE, FWD_RF, FWD_RF, 0);

        // forwarding priority
        nx = '0; nx.rdm = 5; nx.rwm = 1; nx.rs1e = 5; nx.rdw = 5; nx.rww = 1;
        cyc("fwd_mem_prio", NONE, FWD_MEM, FWD_RF, 0);
        nx.rdm = 0;
        cyc("fwd_wb", NONE, FWD_WB, FWD_RF, 0);
        nx = '0; nx.rs1e = 3; nx.rs2e = 3; nx.rdm = 3; nx.rdw = 3; nx.rww = 1;
        cyc("fwd_wb_both", NONE, FWD_WB, FWD_WB, 0);
        nx = '0; nx.rs2e = 9; nx.rdm = 9; nx.rwm = 1; nx.rww = 1;
        cyc("fwd_b_mem_x0", NONE, FWD_RF, FWD_MEM, 0);

        // load-use
        nx = '0; nx.ld = 1; nx.rde = 7; nx.rs2d = 7;
        cyc("load_use", LU, FWD_RF, FWD_RF, 0);
        nx = '0; nx.ld = 1;
        cyc("load_use_x0", NONE, FWD_RF, FWD_RF, 0);
        nx = '0; nx.ld = 1; nx.rde = 12; nx.rs1d = 12;
        cyc("load_use_rs1", LU, FWD_RF, FWD_RF, 0);
        nx.ld = 0;
        cyc("no_load", NONE, FWD_RF, FWD_RF, 0);

        // redirect beats load-use
        nx = '0; nx.ld = 1; nx.rde = 7; nx.rs2d = 7; nx.pc = 1;
        cyc("redir_lu", RD, FWD_RF, FWD_RF, 0);
        nx = '0;
        cyc("cnt_check", NONE, FWD_RF, FWD_RF, 0);

        // memory wait: 3 stall cycles, redirect deferred to ready cycle
        rst_cyc("reset2", FWD_RF, FWD_RF);
        nx = '0; nx.req = 1;
        cyc("mem_wait1", MS, FWD_RF, FWD_RF, 0);
        nx.pc = 1;
        cyc("mem_wait2", MS, FWD_RF, FWD_RF, 0);
        cyc("mem_wait3", MS, FWD_RF, FWD_RF, 0);
        nx.rdy = 1;
        cyc("mem_ready_redir", RD, FWD_RF, FWD_RF, 0);
        nx = '0;
        cyc("after_wait", NONE, FWD_RF, FWD_RF, 0);
        nx = '0; nx.req = 1;
        cyc("rewait", MS, FWD_RF, FWD_RF, 0);
        nx.rdy = 1; nx.ld = 1; nx.rde = 4; nx.rs1d = 4;
        cyc("ready_lu", LU, FWD_RF, FWD_RF, 0);

        // reset in the middle of a wait leaves nothing behind
        nx = '0; nx.req = 1;
        cyc("wait_pre_rst", MS, FWD_RF, FWD_RF, 0);
        rst_cyc("reset_mid_wait", FWD_RF, FWD_RF);
        nx = '0;
        cyc("no_residual", NONE, FWD_RF, FWD_RF, 0);

        // timeout into fault
        nx = '0; nx.req = 1;
        for (int i = 0; i < 5; i++) begin
            cyc("timeout_wait", MS, FWD_RF, FWD_RF, 0);
        end
        cyc("fault", MS, FWD_RF, FWD_RF, 1);
        nx = '0; nx.rdy = 1; nx.rs1e = 5; nx.rdm = 5; nx.rwm = 1; nx.pc = 1;
        cyc("fault_held", MS, FWD_MEM, FWD_RF, 1);
        nx = '0;
        rst_cyc("reset_fault", FWD_RF, FWD_RF);
        cyc("fault_cleared", NONE, FWD_RF, FWD_RF, 0);

        // counter saturation
        nx = '0; nx.ld = 1; nx.rde = 7; nx.rs1d = 7;
        for (int i = 0; i < 20; i++) begin
            cyc("sat", LU, FWD_RF, FWD_RF, 0);
        end
        nx = '0;
        cyc("sat_final", NONE, FWD_RF, FWD_RF, 0);

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            total = total + 1;
            bad   = bad + 1;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter XLEN, default riscv_pkg::XLEN, datapath width (used only for counter sizing checks).
REQ-002 Parameter MEM_TIMEOUT, default 255, max consecutive data-memory wait cycles before fault.
REQ-003 Parameter CNT_W, default 16, width of the performance counters.
REQ-004 clk  in  1  single clock, all state on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 Rs1D, Rs2D  in  5 each  source registers of the instruction in D.
REQ-007 Rs1E, Rs2E, RdE  in  5 each  source and destination registers of the instruction in E.
REQ-008 ResultSrcE0  in  1  the instruction in E is a load.
REQ-009 PCSrcE  in  1  taken branch or jump resolved in E.
REQ-010 RdM, RegWriteM  in  5, 1  destination and write enable of the instruction in M.
REQ-011 RdW, RegWriteW  in  5, 1  destination and write enable of the instruction in W.
REQ-012 dmem_req_M, dmem_ready  in  1 each  data-memory access in M, and memory completion.
REQ-013 StallF, StallD, StallE, StallM  out  1 each  hold the corresponding pipeline register.
REQ-014 FlushD, FlushE, FlushW  out  1 each  clear the corresponding pipeline register to a bubble.
REQ-015 ForwardAE, ForwardBE  out  fwd_sel_e (2)  ALU operand source select in E.
REQ-016 fault  out  1  sticky data-memory timeout indication.
REQ-017 stall_cnt, flush_cnt  out  CNT_W each  saturating performance counters.

Function
REQ-018 Forwarding SHALL be combinational: FWD_MEM when RegWriteM, RdM!=0 and RdM==Rs1E (Rs2E for B); otherwise FWD_WB under the same rule for W; otherwise FWD_RF. M takes priority over W.
REQ-019 A load-use hazard SHALL be ResultSrcE0 & RdE!=0 & (RdE==Rs1D | RdE==Rs2D).
REQ-020 A memory stall SHALL be dmem_req_M & ~dmem_ready.
REQ-021 FSM states: RUN, MEM_WAIT, FAULT (hz_state_e).
REQ-022 RUN, memory stall: StallF=StallD=StallE=StallM=1, FlushW=1, all other flushes 0, in the same cycle; next state MEM_WAIT; wait_cnt<=1.
REQ-023 RUN, no memory stall, PCSrcE=1: FlushD=FlushE=1, no stalls, regardless of load-use.
REQ-024 RUN, no memory stall, PCSrcE=0, load-use: StallF=StallD=1, FlushE=1.
REQ-025 MEM_WAIT, dmem_ready=0: outputs as REQ-022; wait_cnt increments; when wait_cnt==MEM_TIMEOUT, next state FAULT.
REQ-026 MEM_WAIT, dmem_ready=1: no memory stall that cycle; REQ-023/REQ-024 apply to the held E/D contents; next state RUN.
REQ-027 Memory stall SHALL dominate redirect and load-use in every state; a PCSrcE held during MEM_WAIT takes effect on the ready cycle only.
REQ-028 FAULT: all four stalls and FlushW held at 1, fault=1, exit only by reset.
REQ-029 stall_cnt SHALL increment on each cycle with StallF=1; flush_cnt on each cycle with FlushE=1; both saturate at all-ones.
REQ-030 Forwarding outputs SHALL be valid in all states, including FAULT.

Reset
REQ-031 rst_n low SHALL asynchronously force state=RUN, wait_cnt=0, fault=0, stall_cnt=flush_cnt=0.
REQ-032 During reset, all stall/flush outputs SHALL be 0, with the forward selects still driven combinationally.
REQ-033 Reset asserted mid-MEM_WAIT or in FAULT SHALL abort the wait with no residual stall after release.

Structure
REQ-034 hz_state_e and fwd_sel_e (FWD_RF=0, FWD_WB=1, FWD_MEM=2) SHALL live in riscv_pkg.
REQ-035 Forwarding logic SHALL be one combinational sub-module, forward_unit, instantiated twice (A and B).
REQ-036 The FSM, wait counter and performance counters SHALL reside in hazard_ctrl.

Verification
REQ-037 Forwarding: RdM=5, RegWriteM=1, Rs1E=5; RdW=5, RegWriteW=1 -> ForwardAE=FWD_MEM. Then RdM=0 -> ForwardAE=FWD_WB.
REQ-038 Load-use: ResultSrcE0=1, RdE=7, Rs2D=7 -> StallF=StallD=FlushE=1 for one cycle, flush_cnt=1. With RdE=0 -> no stall.
REQ-039 Redirect plus load-use: PCSrcE=1 with the REQ-038 hazard -> FlushD=FlushE=1, StallF=0.
REQ-040 Memory wait: dmem_req_M=1, ready low for 3 cycles then high -> StallF..StallM=1 for 3 cycles, 0 on the 4th cycle; stall_cnt=3; state back to RUN.
REQ-041 Timeout: MEM_TIMEOUT=4, ready never asserted -> fault=1 after wait_cnt reaches 4; stalls held; rst_n pulse clears fault and all stalls.
REQ-042 Saturation: CNT_W=4 with 20 stall cycles -> stall_cnt=15.
